// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin burst arbiter sharing one framebuffer write port between two requesters.
// Drops out-of-range addresses and aborts bursts that stall for too long.
module fb_write_arbiter #(
    parameter int c_ledboards = 30,
    parameter int c_bpc       = 12,
    parameter int c_max_time  = 1024,
    parameter int c_max_type  = 64,
    parameter int c_timeout   = 64,
    parameter int c_channels  = c_ledboards * 32,
    parameter int c_addr_w    = $clog2(c_channels),
    parameter int c_time_w    = $clog2(c_max_time),
    parameter int c_type_w    = $clog2(c_max_type)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [1:0]          i_valid,
    input  logic [1:0]          i_last,
    input  logic [c_addr_w-1:0] i_addr0,
    input  logic [c_addr_w-1:0] i_addr1,
    input  logic [c_bpc-1:0]    i_data0,
    input  logic [c_bpc-1:0]    i_data1,
    input  logic [c_time_w-1:0] i_time0,
    input  logic [c_time_w-1:0] i_time1,
    input  logic [c_type_w-1:0] i_type0,
    input  logic [c_type_w-1:0] i_type1,
    output logic [1:0]          o_ready,
    output logic                o_fb_wen,
    output logic [c_addr_w-1:0] o_fb_waddr,
    output logic [c_bpc-1:0]    o_fb_wdata,
    output logic [c_time_w-1:0] o_fb_time,
    output logic [c_type_w-1:0] o_fb_type,
    output logic [1:0]          o_grant,
    output logic                o_err_addr,
    output logic                o_abort
);
    localparam int c_tmo_w = $clog2(c_timeout);
    localparam logic [c_tmo_w-1:0] c_tmo_end = c_tmo_w'(c_timeout - 2);
    localparam logic [c_addr_w:0] c_lim = (c_addr_w + 1)'(c_channels);

    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic rr, rr_nx, abort_nx, xfer, owner, sel_last, in_range;
    logic [1:0] grant_nx;
    logic [c_tmo_w-1:0] tmo, tmo_nx;
    logic [c_addr_w-1:0] sel_addr;
    logic [c_bpc-1:0] sel_data;
    logic [c_time_w-1:0] sel_time;
    logic [c_type_w-1:0] sel_type;

    assign o_ready  = {2{state == BURST}} & o_grant;
    assign xfer     = |(i_valid & o_ready);
    assign owner    = o_grant[1];
    assign sel_last = owner ? i_last[1] : i_last[0];
    assign sel_addr = owner ? i_addr1 : i_addr0;
    assign sel_data = owner ? i_data1 : i_data0;
    assign sel_time = owner ? i_time1 : i_time0;
    assign sel_type = owner ? i_type1 : i_type0;
    assign in_range = {1'b0, sel_addr} < c_lim;

    // The stall counter is at c_timeout-2 on the last stalled cycle before it would reach c_timeout-1.
    always_comb begin
        state_nx = state;
        grant_nx = o_grant;
        rr_nx    = rr;
        tmo_nx   = tmo;
        abort_nx = 1'b0;
        if (state == IDLE) begin
            tmo_nx = '0;
            if (|i_valid) begin
                state_nx = BURST;
                grant_nx = i_valid[rr] ? (2'b01 << rr) : (2'b10 >> rr);
            end
        end else if (xfer) begin
            tmo_nx = '0;
            if (sel_last) begin
                state_nx = IDLE;
                grant_nx = 2'b00;
                rr_nx    = ~owner;
            end
        end else if (tmo == c_tmo_end) begin
            state_nx = IDLE;
            grant_nx = 2'b00;
            rr_nx    = ~owner;
            abort_nx = 1'b1;
            tmo_nx   = '0;
        end else begin
            tmo_nx = tmo + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            rr         <= 1'b0;
            tmo        <= '0;
            o_grant    <= 2'b00;
            o_fb_wen   <= 1'b0;
            o_fb_waddr <= '0;
            o_fb_wdata <= '0;
            o_fb_time  <= '0;
            o_fb_type  <= '0;
            o_err_addr <= 1'b0;
            o_abort    <= 1'b0;
        end else begin
            state      <= state_nx;
            rr         <= rr_nx;
            tmo        <= tmo_nx;
            o_grant    <= grant_nx;
            o_fb_wen   <= xfer & in_range;
            o_err_addr <= xfer & ~in_range;
            o_abort    <= abort_nx;
            if (xfer && in_range) begin
                o_fb_waddr <= sel_addr;
                o_fb_wdata <= sel_data;
                o_fb_time  <= sel_time;
                o_fb_type  <= sel_type;
            end
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed self-checking bench for fb_write_arbiter.
module tb_fb_write_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] valid, last, ready, grant;
    logic [9:0] addr0, addr1, waddr;
    logic [11:0] data0, data1, wdata;
    logic [9:0] tim0, tim1, wtime;
    logic [5:0] typ0, typ1, wtype;
    logic wen, err_addr, abort;
    int errors = 0;
    int checks = 0;

    fb_write_arbiter dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_last(last),
        .i_addr0(addr0), .i_addr1(addr1), .i_data0(data0), .i_data1(data1),
        .i_time0(tim0), .i_time1(tim1), .i_type0(typ0), .i_type1(typ1),
        .o_ready(ready), .o_fb_wen(wen), .o_fb_waddr(waddr), .o_fb_wdata(wdata),
        .o_fb_time(wtime), .o_fb_type(wtype), .o_grant(grant),
        .o_err_addr(err_addr), .o_abort(abort)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] acc;
        int n0, n1, widx;
        logic [9:0] exp_a [16];
        exp_a = '{0, 1, 2, 3, 64, 65, 66, 67, 4, 5, 6, 7, 68, 69, 70, 71};
        rst = 1'b1; valid = 2'b00; last = 2'b00;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        tim0 = '0; tim1 = '0; typ0 = '0; typ1 = '0;
        tick; tick;
        chk("rst_grant", grant, 0);
        chk("rst_ready", ready, 0);
        chk("rst_wen", wen, 0);
        chk("rst_err", err_addr, 0);
        chk("rst_abort", abort, 0);
        chk("rst_waddr", waddr, 0);
        rst = 1'b0;
        tick;
        chk("idle_grant", grant, 0);

        // T1: port0 16-word burst
        valid = 2'b01; addr0 = 0; data0 = 12'h7FF;
        tick;
        chk("t1_grant", grant, 2'b01);
        chk("t1_nowen_grant", wen, 0);
        for (int i = 0; i < 16; i++) begin
            addr0 = 10'(i);
            data0 = (i % 2 == 0) ? 12'h7FF : 12'h000;
            last = (i == 15) ? 2'b01 : 2'b00;
            chk("t1_ready", ready, 2'b01);
            tick;
            chk("t1_wen", wen, 1);
            chk("t1_waddr", waddr, i);
            chk("t1_wdata", wdata, (i % 2 == 0) ? 12'h7FF : 12'h000);
        end
        chk("t1_grant_end", grant, 0);
        chk("t1_ready_end", ready, 0);
        valid = 2'b00; last = 2'b00;
        tick;
        chk("t1_wen_off", wen, 0);

        // T2: both ports busy from reset, two 4-word bursts each
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n0 = 0; n1 = 0; widx = 0;
        for (int c = 0; c < 25; c++) begin
            valid = {n1 < 8, n0 < 8};
            addr0 = 10'(n0); data0 = 12'(n0);
            addr1 = 10'(64 + n1); data1 = 12'(64 + n1);
            last = {n1 % 4 == 3, n0 % 4 == 3};
            acc = valid & ready;
            tick;
            if (acc[0]) n0++;
            if (acc[1]) n1++;
            if (wen) begin
                if (widx < 16) begin
                    chk("t2_order", waddr, exp_a[widx]);
                    chk("t2_data", wdata, 12'(exp_a[widx]));
                    chk("t2_cycle", c, widx + widx / 4 + 1);
                end
                widx++;
            end
        end
        chk("t2_count", widx, 16);
        chk("t2_n0", n0, 8);
        chk("t2_n1", n1, 8);
        valid = 2'b00; last = 2'b00;

        // T3: out-of-range word mid-burst on port1
        valid = 2'b10; addr1 = 5; data1 = 1;
        tick;
        chk("t3_grant", grant, 2'b10);
        tick;
        chk("t3_wen0", wen, 1);
        chk("t3_addr0", waddr, 5);
        addr1 = 960; data1 = 2;
        tick;
        chk("t3_wen_bad", wen, 0);
        chk("t3_err", err_addr, 1);
        chk("t3_hold", waddr, 5);
        chk("t3_grant_mid", grant, 2'b10);
        addr1 = 7; data1 = 3; last = 2'b10;
        tick;
        chk("t3_wen2", wen, 1);
        chk("t3_addr2", waddr, 7);
        chk("t3_err_off", err_addr, 0);
        chk("t3_grant_end", grant, 0);
        valid = 2'b00; last = 2'b00;
        tick;

        // T4: port0 stalls, port1 pending
        valid = 2'b01; addr0 = 20; data0 = 20;
        tick;
        chk("t4_grant", grant, 2'b01);
        tick;
        chk("t4_wen", wen, 1);
        chk("t4_addr", waddr, 20);
        valid = 2'b10; addr1 = 30; data1 = 30; last = 2'b10;
        for (int k = 0; k < 63; k++) begin
            chk("t4_no_abort", abort, 0);
            chk("t4_ready_held", ready, 2'b01);
            tick;
        end
        chk("t4_abort", abort, 1);
        chk("t4_grant_abort", grant, 0);
        chk("t4_wen_abort", wen, 0);
        chk("t4_ready_abort", ready, 0);
        tick;
        chk("t4_abort_pulse", abort, 0);
        chk("t4_grant_p1", grant, 2'b10);
        tick;
        chk("t4_p1_wen", wen, 1);
        chk("t4_p1_addr", waddr, 30);
        valid = 2'b01; addr0 = 21; last = 2'b01;
        tick;
        chk("t4_regrant", grant, 2'b01);
        tick;
        chk("t4_p0_wen", wen, 1);
        chk("t4_p0_addr", waddr, 21);
        chk("t4_p0_grant_end", grant, 0);
        valid = 2'b00; last = 2'b00;
        tick;

        // T5: reset in the middle of a 10-word burst
        valid = 2'b01;
        tick;
        chk("t5_grant", grant, 2'b01);
        for (int i = 0; i < 5; i++) begin
            addr0 = 10'(100 + i); data0 = 12'(i);
            tick;
            chk("t5_addr", waddr, 100 + i);
        end
        addr0 = 105; data0 = 5; rst = 1'b1;
        tick;
        chk("t5_wen", wen, 0);
        chk("t5_grant_rst", grant, 0);
        chk("t5_ready", ready, 0);
        chk("t5_waddr", waddr, 0);
        chk("t5_wdata", wdata, 0);
        chk("t5_time", wtime, 0);
        chk("t5_type", wtype, 0);
        rst = 1'b0;
        valid = 2'b11; addr0 = 50; addr1 = 51; last = 2'b11;
        tick;
        chk("t5_rr0", grant, 2'b01);
        tick;
        chk("t5_wen_new", wen, 1);
        chk("t5_addr_new", waddr, 50);
        valid = 2'b00; last = 2'b00;
        tick;

        // T6: single-word burst with fade time/type
        valid = 2'b10; addr1 = 200; data1 = 12'hABC; tim1 = 100; typ1 = 3; last = 2'b10;
        tick;
        chk("t6_grant", grant, 2'b10);
        tick;
        chk("t6_wen", wen, 1);
        chk("t6_addr", waddr, 200);
        chk("t6_data", wdata, 12'hABC);
        chk("t6_time", wtime, 100);
        chk("t6_type", wtype, 3);
        chk("t6_grant_end", grant, 0);
        chk("t6_ready_end", ready, 0);
        valid = 2'b00; last = 2'b00;
        tick;
        chk("t6_wen_off", wen, 0);
        chk("t6_time_hold", wtime, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
